// File: rtl/pipe_adder.sv
// pipe_adder: pipelined add/subtract. The carry chain is cut into STAGES slices with registered flags.
// Latency: an op accepted on edge N shows out_valid=1 after edge N+STAGES-1. Throughput is one op per cycle.
// Backpressure: stall freezes every stage; flush drops everything in flight. rst has priority, then flush, then stall.
//
// Ports:
//   clk, rst               rising-edge clock; synchronous active-high reset
//   in_valid, sub, a, b    operation input (sub=1 -> a-b)
//   stall, flush           pipeline freeze / discard all in-flight ops
//   out_valid, sum         result qualifier and result
//   carry, overflow,       MSB carry out (sub: 1 = no borrow), signed overflow,
//   zero, negative         sum==0, sum MSB
// Optional feature: define PIPE_ADDER_SAT_EN to saturate sum on signed overflow.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int W = WIDTH / STAGES;  // bits per carry-chain slice
  localparam int L = STAGES - 1;      // index of the last stage

  // Inputs seen by each stage. Stage 0 is fed from the ports, stage k from register k-1.
  logic [STAGES-1:0]            iv, ic;
  logic [STAGES-1:0][WIDTH-1:0] ia, ib, is;

  // Combinational result of each stage.
  logic [STAGES-1:0][WIDTH-1:0] ns, sn;
  logic [STAGES-1:0]            nc;
  logic [W:0]                   t;

  // Stage registers. Register L is the output register.
  logic [STAGES-1:0]            v_q, c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, s_q;
  logic                         ovf_q, zero_q, neg_q;

  logic [WIDTH-1:0] fs;
  logic             ovf_d, zero_d, neg_d;

  // The last stage does not forward its operands, so those bits have no reader.
  logic unused_tail;
  assign unused_tail = ^{a_q[L], b_q[L]};

  always_comb begin
    iv = '0;
    ic = '0;
    ia = '0;
    ib = '0;
    is = '0;
    ns = '0;
    nc = '0;
    t  = '0;
    // Subtraction inverts B once at entry and injects carry-in 1. Later
    // stages therefore never need to see the sub bit.
    iv[0] = in_valid;
    ia[0] = a;
    ib[0] = sub ? ~b : b;
    ic[0] = sub;
    for (int k = 1; k < STAGES; k++) begin
      iv[k] = v_q[k-1];
      ia[k] = a_q[k-1];
      ib[k] = b_q[k-1];
      is[k] = s_q[k-1];
      ic[k] = c_q[k-1];
    end
    // Stage k fills in slice k (LSB first). It takes its carry-in only from
    // the register before it, so no carry path crosses a stage boundary.
    for (int k = 0; k < STAGES; k++) begin
      t = {1'b0, ia[k][k*W +: W]} + {1'b0, ib[k][k*W +: W]} + {{W{1'b0}}, ic[k]};
      ns[k] = is[k];
      ns[k][k*W +: W] = t[W-1:0];
      nc[k] = t[W];
    end
  end

  // Flags for the final stage. Overflow uses the post-inversion B sign.
  always_comb begin
    fs    = ns[L];
    ovf_d = (ia[L][WIDTH-1] == ib[L][WIDTH-1]) && (ns[L][WIDTH-1] != ia[L][WIDTH-1]);
`ifdef PIPE_ADDER_SAT_EN
    // Clamp toward the sign of A. Overflow needs both operands to share
    // A's sign, so A's sign gives the direction of the true result.
    if (ovf_d) begin
      fs = ia[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    zero_d = (fs == '0);
    neg_d  = fs[WIDTH-1];
    sn     = ns;
    sn[L]  = fs;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      c_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (flush) begin
      // Only the valid bits matter. Datapath contents may stay stale.
      v_q <= '0;
    end else if (!stall) begin
      v_q    <= iv;
      c_q    <= nc;
      a_q    <= ia;
      b_q    <= ib;
      s_q    <= sn;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign out_valid = v_q[L];
  assign sum       = s_q[L];
  assign carry     = c_q[L];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: checks pipe_adder at STAGES=2, 1 and 4 (WIDTH=32).
// All three instances get the same stimulus. Each one is compared every cycle against an arithmetic reference.
// Directed cases cover the corner values, stall timing, flush and reset.
module tb_pipe_adder;

  typedef struct packed {
    logic        v;   // result valid
    logic        k;   // data fields are defined (compare them)
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
    logic        n;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, sub, stall, flush;
  logic [31:0] a, b;

  logic        ov [3];
  logic [31:0] sm [3];
  logic        cy [3];
  logic        of [3];
  logic        zr [3];
  logic        ng [3];

  int   npass = 0;
  int   nchk  = 0;
  int   dep [3] = '{2, 1, 4};
  ent_t mdl [3][4];
  ent_t mo  [3];

  always #5 clk = ~clk;

  pipe_adder #(.WIDTH(32), .STAGES(2)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .stall(stall), .flush(flush), .out_valid(ov[0]), .sum(sm[0]),
    .carry(cy[0]), .overflow(of[0]), .zero(zr[0]), .negative(ng[0]));
  pipe_adder #(.WIDTH(32), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .stall(stall), .flush(flush), .out_valid(ov[1]), .sum(sm[1]),
    .carry(cy[1]), .overflow(of[1]), .zero(zr[1]), .negative(ng[1]));
  pipe_adder #(.WIDTH(32), .STAGES(4)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .stall(stall), .flush(flush), .out_valid(ov[2]), .sum(sm[2]),
    .carry(cy[2]), .overflow(of[2]), .zero(zr[2]), .negative(ng[2]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected result from integer arithmetic: exact signed result for overflow
  // and saturation, unsigned comparisons for carry/borrow.
  function automatic ent_t ref_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    ent_t        e;
    longint      sx, sy, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = s ? sx - sy : sx + sy;
    e   = '0;
    e.v = 1'b1;
    e.k = 1'b1;
    e.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    e.c = s ? (ux >= uy) : ((ux + uy) >= 64'h1_0000_0000);
    e.s = r[31:0];
`ifdef PIPE_ADDER_SAT_EN
    if (e.o) e.s = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    e.z = (e.s == 32'd0);
    e.n = e.s[31];
    return e;
  endfunction

  // Each instance is modelled as a delay line of expected results. Its depth is the latency.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) mdl[i][k] = '0;
        mo[i]   = '0;
        mo[i].k = 1'b1;
      end else if (flush) begin
        for (int k = 0; k < 4; k++) mdl[i][k].v = 1'b0;
        mo[i].v = 1'b0;
        mo[i].k = 1'b0;
      end else if (!stall) begin
        for (int k = dep[i] - 1; k > 0; k--) mdl[i][k] = mdl[i][k-1];
        mdl[i][0] = in_valid ? ref_op(a, b, sub) : ent_t'('0);
        mo[i]     = mdl[i][dep[i] - 1];
      end
    end
  endtask

  task automatic cmp_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_out_valid", i), 64'(ov[i]), 64'(mo[i].v));
      if (mo[i].k) begin
        chk($sformatf("u%0d_sum", i),      64'(sm[i]), 64'(mo[i].s));
        chk($sformatf("u%0d_carry", i),    64'(cy[i]), 64'(mo[i].c));
        chk($sformatf("u%0d_overflow", i), 64'(of[i]), 64'(mo[i].o));
        chk($sformatf("u%0d_zero", i),     64'(zr[i]), 64'(mo[i].z));
        chk($sformatf("u%0d_negative", i), 64'(ng[i]), 64'(mo[i].n));
      end
    end
  endtask

  // One clock: update the model on the rising edge and compare on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cmp_all();
  endtask

  task automatic set_op(input logic v, input logic [31:0] x, input logic [31:0] y, input logic s);
    in_valid = v;
    a        = x;
    b        = y;
    sub      = s;
  endtask

  logic [31:0] corner [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
  logic [31:0] exp034, exp038;
  int          seen, lat;
  logic        found;

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_op(1'b0, 32'h0, 32'h0, 1'b0);
`ifdef PIPE_ADDER_SAT_EN
    exp034 = 32'h8000_0000;
    exp038 = 32'h7FFF_FFFF;
`else
    exp034 = 32'h0000_0001;
    exp038 = 32'h8000_0000;
`endif
    // Reset. rst=1 must also win over stall and flush.
    step();
    stall = 1'b1; flush = 1'b1; set_op(1'b1, 32'h1234, 32'h1, 1'b0);
    step();
    chk("reset_out_valid", 64'(ov[0]), 64'd0);
    chk("reset_sum", 64'(sm[0]), 64'd0);
    stall = 1'b0; flush = 1'b0; rst = 1'b0;

    // Three back-to-back ops, first one accepted on the first edge with rst=0.
    set_op(1'b1, 32'h8000_0000, 32'h8000_0001, 1'b0); step();
    set_op(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0); step();
    chk("r034_valid", 64'(ov[0]), 64'd1);
    chk("r034_sum", 64'(sm[0]), 64'(exp034));
    chk("r034_carry", 64'(cy[0]), 64'd1);
    chk("r034_overflow", 64'(of[0]), 64'd1);
    chk("r034_zero", 64'(zr[0]), 64'd0);
    set_op(1'b1, 32'd5, 32'd7, 1'b1); step();
    chk("r035_valid", 64'(ov[0]), 64'd1);
    chk("r035_sum", 64'(sm[0]), 64'd0);
    chk("r035_flags", 64'({cy[0], zr[0], of[0], ng[0]}), 64'b1100);
    set_op(1'b0, 32'h0, 32'h0, 1'b0); step();
    chk("r036_valid", 64'(ov[0]), 64'd1);
    chk("r036_sum", 64'(sm[0]), 64'hFFFF_FFFE);
    chk("r036_flags", 64'({cy[0], ng[0], of[0]}), 64'b010);
    step();
    chk("r036_bubble", 64'(ov[0]), 64'd0);

    // Stall for 3 cycles right after the op is accepted.
    set_op(1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0); step();
    stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      set_op(1'b1, $urandom, $urandom, 1'($urandom));
      step();
    end
    stall = 1'b0; set_op(1'b0, 32'h0, 32'h0, 1'b0);
    found = 1'b0; lat = 3;
    for (int n = 0; n < 10 && !found; n++) begin
      step();
      lat++;
      if (ov[0]) found = 1'b1;
    end
    chk("stall_found", 64'(found), 64'd1);
    chk("stall_latency", 64'(lat), 64'd4);
    chk("r038_sum", 64'(sm[0]), 64'(exp038));
    chk("r038_overflow", 64'(of[0]), 64'd1);
    repeat (4) step();

    // Flush with ops in flight. u0 gets flush together with a new op that
    // must be discarded. u2 gets two ops, then a flush.
    set_op(1'b1, 32'h11, 32'h22, 1'b0); step();
    flush = 1'b1; set_op(1'b1, 32'h33, 32'h44, 1'b0); step();
    flush = 1'b0; set_op(1'b0, 32'h0, 32'h0, 1'b0);
    seen = 0;
    for (int n = 0; n < 6; n++) begin step(); if (ov[0]) seen++; end
    chk("flush_u0_valids", 64'(seen), 64'd0);
    set_op(1'b1, 32'h55, 32'h66, 1'b1); step();
    set_op(1'b1, 32'h77, 32'h88, 1'b1); step();
    flush = 1'b1; stall = 1'b1; set_op(1'b0, 32'h0, 32'h0, 1'b0); step();
    flush = 1'b0; stall = 1'b0;
    seen = 0;
    if (ov[2]) seen++;
    for (int n = 0; n < 6; n++) begin step(); if (ov[2]) seen++; end
    chk("flush_u2_valids", 64'(seen), 64'd0);

    // Random stream with stalls, flushes and a reset in the middle.
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst   = (cyc >= 300 && cyc < 302);
      stall = ($urandom % 10) == 0;
      flush = ($urandom % 25) == 0;
      set_op(1'(($urandom % 10) < 7),
             ($urandom % 4 == 0) ? corner[$urandom % 5] : 32'($urandom),
             ($urandom % 4 == 0) ? corner[$urandom % 5] : 32'($urandom),
             1'($urandom));
      step();
      if (cyc == 301) begin
        chk("midrst_out_valid", 64'({ov[0], ov[1], ov[2]}), 64'd0);
        chk("midrst_sum", 64'(sm[2]), 64'd0);
      end
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
